// File: rtl/hazard_stall_unit.sv
// Pipeline hazard control: load-use stalls, branch and jump flushes, and memory-wait freeze
// with timeout detection. It also keeps saturating stall and flush statistics.
module hazard_stall_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_decode,
  input  logic [4:0]       rt_decode,
  input  logic             uses_rt_decode,
  input  logic [4:0]       rt_execute,
  input  logic             mem_read_execute,
  input  logic             jump_decode,
  input  logic             branch_taken_execute,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_freeze,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              load_use;
  logic              mem_freeze;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  assign load_use = mem_read_execute && (rt_execute != 5'd0) &&
                    ((rt_execute == rs_decode) ||
                     (uses_rt_decode && (rt_execute == rt_decode)));

  assign wait_inc = wait_q + WAIT_W'(1);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin : next_state
    state_d    = state_q;
    wait_d     = wait_q;
    timeout_d  = timeout_q;
    mem_freeze = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          mem_freeze = 1'b1;
          state_d    = MEM_WAIT;
          wait_d     = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          mem_freeze = 1'b1;
          if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
            timeout_d = 1'b1;
            wait_d    = '0;
            state_d   = RUN;
          end else begin
            wait_d = wait_inc;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Reset overrides the controls combinationally, so the pipe is held and flushed while it is low.
  always_comb begin : ctl_outputs
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pipe_freeze = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (mem_freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (branch_taken_execute) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (jump_decode) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin : stats_next
    stall_d = stall_q;
    flush_d = flush_q;
    if (idex_bubble && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if ((ifid_flush || idex_flush) && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (small counters/short timeout, and defaults) driven
// by the same stimulus and compared each cycle against a priority-rule model of the unit.
module tb_hazard_stall_unit;

  localparam int A_CW = 2;
  localparam int A_TO = 4;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic pipe_freeze;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
  } ctl_t;

  localparam ctl_t C_NORMAL = 6'b110000;
  localparam ctl_t C_STALL  = 6'b000100;
  localparam ctl_t C_JUMP   = 6'b110010;
  localparam ctl_t C_BRANCH = 6'b110011;
  localparam ctl_t C_FREEZE = 6'b001000;
  localparam ctl_t C_RESET  = 6'b001011;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] rt_ex;
    logic       mr;
    logic       jmp;
    logic       br;
    ctl_t       exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [4:0] rs_decode, rt_decode, rt_execute;
  logic       uses_rt_decode, mem_read_execute, jump_decode, branch_taken_execute;
  logic       mem_req, mem_ready;

  logic pcw_a, ifw_a, frz_a, bub_a, iff_a, idf_a, tout_a;
  logic pcw_b, ifw_b, frz_b, bub_b, iff_b, idf_b, tout_b;
  logic [A_CW-1:0] stall_a, flush_a;
  logic [15:0]     stall_b, flush_b;
  ctl_t ctl_a, ctl_b;

  assign ctl_a = {pcw_a, ifw_a, frz_a, bub_a, iff_a, idf_a};
  assign ctl_b = {pcw_b, ifw_b, frz_b, bub_b, iff_b, idf_b};

  hazard_stall_unit #(.CNT_W(A_CW), .MEM_TIMEOUT(A_TO)) dut_a (
    .clk(clk), .reset(reset),
    .rs_decode(rs_decode), .rt_decode(rt_decode), .uses_rt_decode(uses_rt_decode),
    .rt_execute(rt_execute), .mem_read_execute(mem_read_execute),
    .jump_decode(jump_decode), .branch_taken_execute(branch_taken_execute),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pcw_a), .ifid_write(ifw_a), .pipe_freeze(frz_a), .idex_bubble(bub_a),
    .ifid_flush(iff_a), .idex_flush(idf_a), .mem_timeout(tout_a),
    .stall_count(stall_a), .flush_count(flush_a)
  );

  hazard_stall_unit dut_b (
    .clk(clk), .reset(reset),
    .rs_decode(rs_decode), .rt_decode(rt_decode), .uses_rt_decode(uses_rt_decode),
    .rt_execute(rt_execute), .mem_read_execute(mem_read_execute),
    .jump_decode(jump_decode), .branch_taken_execute(branch_taken_execute),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pcw_b), .ifid_write(ifw_b), .pipe_freeze(frz_b), .idex_bubble(bub_b),
    .ifid_flush(iff_b), .idex_flush(idf_b), .mem_timeout(tout_b),
    .stall_count(stall_b), .flush_count(flush_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  int lim_to[2]  = '{A_TO, 255};
  int lim_cnt[2] = '{3, 65535};
  bit m_wait[2];
  int m_wcnt[2];
  bit m_tout[2];
  int m_stall[2];
  int m_flush[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t model_ctl(input bit waiting);
    bit freeze;
    bit lu;
    if (!reset) return C_RESET;
    freeze = waiting ? !mem_ready : (mem_req && !mem_ready);
    lu = mem_read_execute && (rt_execute != 0) &&
         ((rt_execute == rs_decode) || (uses_rt_decode && (rt_execute == rt_decode)));
    if (freeze)                    return C_FREEZE;
    if (branch_taken_execute)      return C_BRANCH;
    if (lu)                        return C_STALL;
    if (jump_decode)               return C_JUMP;
    return C_NORMAL;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 0; m_wcnt[i] = 0; m_tout[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  endtask

  task automatic model_advance();
    for (int i = 0; i < 2; i++) begin
      ctl_t c;
      c = model_ctl(m_wait[i]);
      if (!reset) begin
        m_wait[i] = 0; m_wcnt[i] = 0; m_tout[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end else begin
        if (c.pipe_freeze) begin
          if (!m_wait[i]) begin
            m_wait[i] = 1;
            m_wcnt[i] = 0;
          end else begin
            m_wcnt[i]++;
            if (m_wcnt[i] == lim_to[i]) begin
              m_tout[i] = 1;
              m_wcnt[i] = 0;
              m_wait[i] = 0;
            end
          end
        end else begin
          m_wait[i] = 0;
        end
        if (c.idex_bubble && m_stall[i] < lim_cnt[i]) m_stall[i]++;
        if ((c.ifid_flush || c.idex_flush) && m_flush[i] < lim_cnt[i]) m_flush[i]++;
      end
    end
  endtask

  // One clock: compare at the falling edge, then advance the model on the rising edge.
  task automatic cycle(input bit has_exp = 0, input ctl_t exp = C_NORMAL, input string nm = "");
    @(negedge clk);
    if (!reset) model_zero();
    if (has_exp) begin
      check({nm, "_a"}, {26'd0, ctl_a}, {26'd0, exp});
      check({nm, "_b"}, {26'd0, ctl_b}, {26'd0, exp});
    end
    check("model_ctl_a", {26'd0, ctl_a}, {26'd0, model_ctl(m_wait[0])});
    check("model_ctl_b", {26'd0, ctl_b}, {26'd0, model_ctl(m_wait[1])});
    check("stall_count_a", 32'(stall_a), 32'(m_stall[0]));
    check("flush_count_a", 32'(flush_a), 32'(m_flush[0]));
    check("stall_count_b", 32'(stall_b), 32'(m_stall[1]));
    check("flush_count_b", 32'(flush_b), 32'(m_flush[1]));
    check("mem_timeout_a", 32'(tout_a), 32'(m_tout[0]));
    check("mem_timeout_b", 32'(tout_b), 32'(m_tout[1]));
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle_inputs();
    rs_decode = 0; rt_decode = 0; uses_rt_decode = 0; rt_execute = 0;
    mem_read_execute = 0; jump_decode = 0; branch_taken_execute = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    cycle(1, C_RESET, "reset_ctl");
    reset = 1'b1;
  endtask

  task automatic set_load_use();
    idle_inputs();
    mem_read_execute = 1; rt_execute = 5'd8; rs_decode = 5'd8;
  endtask

  vec_t vecs[10];

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_zero();

    vecs[0] = '{"normal",         5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORMAL};
    vecs[1] = '{"lu_rs",          5'd8, 5'd2, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, C_STALL};
    vecs[2] = '{"rt_itype",       5'd3, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, C_NORMAL};
    vecs[3] = '{"lu_rt",          5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, C_STALL};
    vecs[4] = '{"rt_ex_zero",     5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, C_NORMAL};
    vecs[5] = '{"not_load",       5'd8, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, C_NORMAL};
    vecs[6] = '{"jump",           5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, C_JUMP};
    vecs[7] = '{"lu_over_jump",   5'd8, 5'd2, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, C_STALL};
    vecs[8] = '{"br_over_all",    5'd8, 5'd2, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, C_BRANCH};
    vecs[9] = '{"branch",         5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, C_BRANCH};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    foreach (vecs[i]) begin
      idle_inputs();
      rs_decode = vecs[i].rs; rt_decode = vecs[i].rt; uses_rt_decode = vecs[i].uses_rt;
      rt_execute = vecs[i].rt_ex; mem_read_execute = vecs[i].mr;
      jump_decode = vecs[i].jmp; branch_taken_execute = vecs[i].br;
      cycle(1, vecs[i].exp, vecs[i].name);
    end

    // Single load-use stall counts exactly once.
    do_reset();
    set_load_use();
    cycle(1, C_STALL, "single_stall");
    idle_inputs();
    check("stall_one_b", 32'(stall_b), 32'd1);
    check("stall_one_a", 32'(stall_a), 32'd1);

    // Branch wins over a simultaneous load-use and jump; counted as one flush cycle.
    do_reset();
    set_load_use();
    jump_decode = 1; branch_taken_execute = 1;
    cycle(1, C_BRANCH, "branch_priority");
    idle_inputs();
    check("flush_one_b", 32'(flush_b), 32'd1);
    check("stall_zero_b", 32'(stall_b), 32'd0);

    // Saturation of the narrow stall counter.
    do_reset();
    set_load_use();
    repeat (5) cycle(1, C_STALL, "sat_stall");
    idle_inputs();
    check("stall_sat_a", 32'(stall_a), 32'd3);
    check("stall_five_b", 32'(stall_b), 32'd5);

    // Three frozen cycles, released in the ready cycle, then back in RUN.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (3) cycle(1, C_FREEZE, "mem_freeze");
    mem_ready = 1;
    cycle(1, C_NORMAL, "mem_ready_release");
    mem_req = 0; mem_ready = 0;
    cycle(1, C_NORMAL, "back_in_run");

    // Timeout on the short-timeout instance after four waiting cycles; sticky afterwards.
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (4) cycle();
    check("timeout_not_yet", 32'(tout_a), 32'd0);
    cycle();
    check("timeout_set", 32'(tout_a), 32'd1);
    mem_req = 0; mem_ready = 1;
    repeat (3) cycle();
    check("timeout_sticky", 32'(tout_a), 32'd1);
    check("timeout_b_clear", 32'(tout_b), 32'd0);
    do_reset();
    check("timeout_reset", 32'(tout_a), 32'd0);
    check("flush_reset_a", 32'(flush_a), 32'd0);

    // Reset in the middle of a wait aborts it without flagging a timeout.
    mem_req = 1; mem_ready = 0;
    repeat (4) cycle();
    reset = 1'b0;
    cycle(1, C_RESET, "reset_mid_wait");
    check("abort_no_timeout", 32'(tout_a), 32'd0);
    reset = 1'b1;
    mem_req = 0; mem_ready = 0;
    cycle(1, C_NORMAL, "run_after_abort");
    check("abort_no_timeout_later", 32'(tout_a), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rs_decode            = 5'($urandom_range(3));
      rt_decode            = 5'($urandom_range(3));
      rt_execute           = 5'($urandom_range(3));
      uses_rt_decode       = ($urandom_range(1) == 1);
      mem_read_execute     = ($urandom_range(9) < 4);
      jump_decode          = ($urandom_range(9) < 2);
      branch_taken_execute = ($urandom_range(19) < 3);
      mem_req              = ($urandom_range(9) < 3);
      mem_ready            = ($urandom_range(9) < 6);
      if (!reset) reset = 1'b1;
      else        reset = ($urandom_range(199) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
